// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, instruction register and a
// return-address stack for CALL/RET. The ROM is read combinationally
// from oAddress. Redirects (iCall > iRet > iJump) override iStall and
// insert one invalid bubble.
// Optional build macro FETCH_STACK_GUARD_EN: suppress stack overflow/underflow
// and raise a sticky oStackError. Without it the stack pointer wraps.
module instruction_fetch #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [27:0] iInstruction,
  output logic [15:0] oAddress,
  output logic [27:0] oInstruction,
  output logic [15:0] oInstrAddress,
  output logic        oValid,
  input  logic        iStall,
  input  logic        iJump,
  input  logic        iCall,
  input  logic        iRet,
  input  logic [15:0] iTarget,
  output logic [4:0]  oStackDepth,
  output logic        oStackError
);

  localparam int unsigned SPW       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_MAX = 5'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  logic [15:0]    pc;
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic [15:0]    stack_mem [STACK_DEPTH];

  logic        redirect;
  logic        do_call;
  logic        do_ret;
  logic        stack_full;
  logic        stack_empty;
  logic        push_en;
  logic        pop_en;
  logic [15:0] ret_addr;
  logic [15:0] pop_val;
  logic [15:0] next_redirect_pc;

  assign oAddress = pc;

  // Redirect decode, stack push/pop qualification and redirect target
  always_comb begin
    do_call     = iCall;
    do_ret      = iRet & ~iCall;
    redirect    = iCall | iRet | iJump;
    stack_full  = (oStackDepth == DEPTH_MAX);
    stack_empty = (oStackDepth == 5'd0);
    sp_dec      = sp - SP_ONE;
    ret_addr    = oInstrAddress + 16'd1;
`ifdef FETCH_STACK_GUARD_EN
    push_en = do_call & ~stack_full;
    pop_en  = do_ret & ~stack_empty;
    pop_val = stack_empty ? RESET_PC : stack_mem[sp_dec];
`else
    push_en = do_call;
    pop_en  = do_ret;
    pop_val = stack_mem[sp_dec];
`endif
    if (do_call) begin
      next_redirect_pc = iTarget;
    end else if (do_ret) begin
      next_redirect_pc = pop_val;
    end else begin
      next_redirect_pc = iTarget;
    end
  end

  // PC, instruction register and stack bookkeeping
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc            <= RESET_PC;
      oInstruction  <= '0;
      oInstrAddress <= '0;
      oValid        <= 1'b0;
      sp            <= '0;
      oStackDepth   <= '0;
    end else if (redirect) begin
      pc     <= next_redirect_pc;
      oValid <= 1'b0;
      if (push_en) begin
        sp <= sp + SP_ONE;
      end else if (pop_en) begin
        sp <= sp_dec;
      end
      // Depth saturates even when the pointer itself wraps
      if (do_call && !stack_full) begin
        oStackDepth <= oStackDepth + 5'd1;
      end else if (do_ret && !stack_empty) begin
        oStackDepth <= oStackDepth - 5'd1;
      end
    end else if (!iStall) begin
      oInstruction  <= iInstruction;
      oInstrAddress <= pc;
      oValid        <= 1'b1;
      pc            <= pc + 16'd1;
    end
  end

  // Stack storage; contents survive reset, only the pointer is cleared
  always_ff @(posedge Clock) begin
    if (!Reset && push_en) begin
      stack_mem[sp] <= ret_addr;
    end
  end

`ifdef FETCH_STACK_GUARD_EN
  logic stack_err;

  // Sticky overflow/underflow flag, cleared only by reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stack_err <= 1'b0;
    end else if ((do_call && stack_full) || (do_ret && stack_empty)) begin
      stack_err <= 1'b1;
    end
  end

  assign oStackError = stack_err;
`else
  assign oStackError = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. ROM model returns {4'hA, address}.
module tb_instruction_fetch;

  logic        Clock;
  logic        Reset;
  logic [27:0] iInstruction;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic [15:0] oInstrAddress;
  logic        oValid;
  logic        iStall;
  logic        iJump;
  logic        iCall;
  logic        iRet;
  logic [15:0] iTarget;
  logic [4:0]  oStackDepth;
  logic        oStackError;

  int unsigned n_checks;
  int unsigned n_errors;

  instruction_fetch #(
    .STACK_DEPTH(8),
    .RESET_PC(16'h0000)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iInstruction(iInstruction),
    .oAddress(oAddress),
    .oInstruction(oInstruction),
    .oInstrAddress(oInstrAddress),
    .oValid(oValid),
    .iStall(iStall),
    .iJump(iJump),
    .iCall(iCall),
    .iRet(iRet),
    .iTarget(iTarget),
    .oStackDepth(oStackDepth),
    .oStackError(oStackError)
  );

  function automatic logic [27:0] rom(input logic [15:0] a);
    return 28'({4'hA, a});
  endfunction

  assign iInstruction = rom(oAddress);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_redirect();
    iJump = 1'b0;
    iCall = 1'b0;
    iRet  = 1'b0;
  endtask

  logic [15:0] pushed [9];
  logic [15:0] cur;

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset   = 1'b1;
    iStall  = 1'b0;
    iJump   = 1'b0;
    iCall   = 1'b0;
    iRet    = 1'b0;
    iTarget = 16'h0000;

    // Reset state
    tick();
    chk("rst_addr", 32'(oAddress), 32'h0);
    chk("rst_valid", 32'(oValid), 32'h0);
    chk("rst_ir", 32'(oInstruction), 32'h0);
    chk("rst_depth", 32'(oStackDepth), 32'h0);
    chk("rst_err", 32'(oStackError), 32'h0);
    tick();
    Reset = 1'b0;

    // Sequential fetch after reset release
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_iaddr", 32'(oInstrAddress), 32'(i));
      chk("seq_valid", 32'(oValid), 32'h1);
      chk("seq_instr", 32'(oInstruction), 32'(rom(16'(i))));
    end
    for (int i = 4; i <= 10; i++) tick();
    chk("pre_call_iaddr", 32'(oInstrAddress), 32'd10);

    // Call from 10 to 32, then return to 11
    iCall = 1'b1; iTarget = 16'd32;
    tick();
    clear_redirect();
    chk("call_bubble", 32'(oValid), 32'h0);
    chk("call_pc", 32'(oAddress), 32'd32);
    chk("call_depth", 32'(oStackDepth), 32'd1);
    tick();
    chk("call_iaddr", 32'(oInstrAddress), 32'd32);
    chk("call_valid", 32'(oValid), 32'h1);
    tick();
    iRet = 1'b1;
    tick();
    clear_redirect();
    chk("ret_bubble", 32'(oValid), 32'h0);
    chk("ret_depth", 32'(oStackDepth), 32'd0);
    tick();
    chk("ret_iaddr", 32'(oInstrAddress), 32'd11);

    // Stall at address 5, then jump during stall
    iJump = 1'b1; iTarget = 16'd5;
    tick();
    clear_redirect();
    tick();
    chk("j5_iaddr", 32'(oInstrAddress), 32'd5);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_iaddr", 32'(oInstrAddress), 32'd5);
      chk("stall_instr", 32'(oInstruction), 32'(rom(16'd5)));
      chk("stall_pc", 32'(oAddress), 32'd6);
      chk("stall_valid", 32'(oValid), 32'h1);
    end
    iJump = 1'b1; iTarget = 16'd14;
    tick();
    clear_redirect();
    iStall = 1'b0;
    chk("stall_jmp_bubble", 32'(oValid), 32'h0);
    chk("stall_jmp_pc", 32'(oAddress), 32'd14);
    tick();
    chk("stall_jmp_iaddr", 32'(oInstrAddress), 32'd14);

    // Call beats return in the same cycle
    iCall = 1'b1; iRet = 1'b1; iTarget = 16'd60;
    tick();
    clear_redirect();
    chk("prio_call_pc", 32'(oAddress), 32'd60);
    chk("prio_call_depth", 32'(oStackDepth), 32'd1);
    tick();
    chk("prio_call_iaddr", 32'(oInstrAddress), 32'd60);

    // Return beats jump in the same cycle
    iRet = 1'b1; iJump = 1'b1; iTarget = 16'd99;
    tick();
    clear_redirect();
    chk("prio_ret_pc", 32'(oAddress), 32'd15);
    chk("prio_ret_depth", 32'(oStackDepth), 32'd0);
    tick();
    chk("prio_ret_iaddr", 32'(oInstrAddress), 32'd15);

    // Nine nested calls into an eight-entry stack
    cur = 16'd15;
    for (int k = 0; k < 9; k++) begin
      pushed[k] = cur + 16'd1;
      iCall = 1'b1; iTarget = 16'((k + 1) * 256);
      tick();
      clear_redirect();
      tick();
      cur = 16'((k + 1) * 256);
    end
    chk("nest_iaddr", 32'(oInstrAddress), 32'h900);
    chk("nest_depth", 32'(oStackDepth), 32'd8);
`ifdef FETCH_STACK_GUARD_EN
    chk("nest_err", 32'(oStackError), 32'h1);
    for (int k = 7; k >= 0; k--) begin
      iRet = 1'b1;
      tick();
      clear_redirect();
      chk("unwind_pc", 32'(oAddress), 32'(pushed[k]));
      tick();
    end
    chk("unwind_depth", 32'(oStackDepth), 32'd0);
    iRet = 1'b1;
    tick();
    clear_redirect();
    chk("pop_empty_pc", 32'(oAddress), 32'h0);
    chk("pop_empty_err", 32'(oStackError), 32'h1);
    tick();
`else
    chk("nest_err", 32'(oStackError), 32'h0);
    iRet = 1'b1;
    tick();
    clear_redirect();
    chk("wrap_ret_pc", 32'(oAddress), 32'(pushed[8]));
    chk("wrap_ret_depth", 32'(oStackDepth), 32'd7);
    tick();
`endif

    // PC wrap from FFFF to 0000
    iJump = 1'b1; iTarget = 16'hFFFF;
    tick();
    clear_redirect();
    tick();
    chk("wrap_iaddr", 32'(oInstrAddress), 32'hFFFF);
    chk("wrap_pc", 32'(oAddress), 32'h0);

    // Asynchronous reset while stalled
    iStall = 1'b1;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    chk("async_pc", 32'(oAddress), 32'h0);
    chk("async_ir", 32'(oInstruction), 32'h0);
    chk("async_iaddr", 32'(oInstrAddress), 32'h0);
    chk("async_valid", 32'(oValid), 32'h0);
    chk("async_depth", 32'(oStackDepth), 32'h0);
    chk("async_err", 32'(oStackError), 32'h0);
    tick();
    Reset  = 1'b0;
    iStall = 1'b0;
    tick();
    chk("rerun_iaddr", 32'(oInstrAddress), 32'h0);
    chk("rerun_valid", 32'(oValid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL provide parameters, one per line:
- STACK_DEPTH, 8, return-address stack entries (power of two, 2..16)
- RESET_PC, 16'h0000, PC value after reset
REQ-002 SHALL provide ports, one per line:
- Clock  input  1  single clock; all state on rising edge
- Reset  input  1  asynchronous, active-high
- iInstruction  input  28  instruction word from program ROM for oAddress
- oAddress  output  16  program counter, drives ROM iAddress
- oInstruction  output  28  registered instruction to decode/execute
- oInstrAddress  output  16  ROM address that oInstruction came from
- oValid  output  1  oInstruction is valid, in-path
- iStall  input  1  execute busy: hold PC and instruction register
- iJump  input  1  redirect to iTarget (JMP, taken BLE)
- iCall  input  1  push return address, redirect to iTarget
- iRet  input  1  pop return address, redirect to it
- iTarget  input  16  redirect target for iJump/iCall
- oStackDepth  output  5  current return-stack occupancy
- oStackError  output  1  sticky overflow/underflow flag
REQ-003 SHALL use one clock and asynchronous active-high Reset (Clock, Reset).

Function
REQ-004 ROM access SHALL be combinational: oAddress equals PC register; iInstruction is sampled same cycle.
REQ-005 Normal cycle (no stall, no redirect): IR <= iInstruction, oInstrAddress <= PC, oValid <= 1, PC <= PC+1.
REQ-006 PC increment SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-007 iStall=1 with no redirect: PC, IR, oInstrAddress, oValid hold.
REQ-008 Redirect (any of iJump/iCall/iRet) SHALL override iStall, take effect next edge, and set oValid <= 0 for exactly one cycle (wrong-path word discarded).
REQ-009 Redirect priority: iCall > iRet > iJump; lower-priority requests in the same cycle are ignored.
REQ-010 iCall: push oInstrAddress+1 (16-bit wrap), PC <= iTarget.
REQ-011 iRet: pop top entry, PC <= popped value.
REQ-012 iJump: PC <= iTarget; stack untouched.
REQ-013 Redirect fetch latency: first target instruction valid on oInstruction 2 edges after redirect assertion.
REQ-014 Stack SHALL be LIFO, oStackDepth = entries held (0..STACK_DEPTH).
REQ-015 Push while full / pop while empty: behaviour per REQ-020/021; PC redirect still occurs (pop-empty yields RESET_PC).
REQ-016 Redirect inputs while oValid=0 SHALL still be honoured.

Reset
REQ-017 On Reset assertion, immediately: PC=RESET_PC, IR=28'd0, oInstrAddress=16'd0, oValid=0, stack pointer=0, oStackDepth=0, oStackError=0.
REQ-018 Reset mid-redirect or mid-stall SHALL discard the pending operation; stack contents need not be cleared.
REQ-019 First valid instruction (address RESET_PC) SHALL appear on oInstruction after first rising edge with Reset low.

Configuration
REQ-020 With FETCH_STACK_GUARD_EN defined: push when full and pop when empty are suppressed (pointer unchanged) and set oStackError=1, sticky until Reset.
REQ-021 Without FETCH_STACK_GUARD_EN: pointer wraps modulo STACK_DEPTH (oldest entry overwritten; pop-empty returns stale entry), oStackDepth saturates 0..STACK_DEPTH, oStackError tied 0.

Verification
REQ-022 Reset release, ROM model returns {4'hA,address}, no stall -> oInstrAddress 0,1,2,3 on consecutive cycles, oValid=1 from first edge.
REQ-023 iCall, iTarget=16'd32, while oInstrAddress=16'd10 -> one bubble, then oInstrAddress=32, oStackDepth=1; later iRet -> bubble, then oInstrAddress=11, depth 0.
REQ-024 iStall held 3 cycles at oInstrAddress=5 -> oInstruction/oAddress frozen; iJump iTarget=14 during stall -> redirect taken, oInstrAddress=14 after bubble.
REQ-025 iCall and iRet same cycle, iTarget=60 -> call wins, PC=60, depth +1.
REQ-026 9 nested calls, STACK_DEPTH=8: with macro -> depth 8, oStackError=1, 8 returns unwind correctly; without -> oStackError=0, first return lands on 9th call's return address.
REQ-027 PC at 16'hFFFF unstalled -> next oAddress 16'h0000; Reset asserted mid-stall -> all outputs at REQ-017 values without clock edge.
